adder_multicycle: RTL and testbench

Parametrised multi-cycle adder/subtractor. It processes an N-bit operand pair in W-bit slices, one slice per clock, with a registered carry chained between slices. It trades latency (N/W cycles) for a short W-bit carry path. Input and output use valid/ready handshakes, so it can sit between pipeline stages in the datapath/ALU.

---
 rtl/adder_multicycle.sv | 105 ++++++++++
 tb/tb_adder_multicycle.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_multicycle.sv
// rtl/adder_multicycle.sv - Sliced multi-cycle adder/subtractor with valid/ready handshakes
module adder_multicycle #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         Cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] S,
    output logic         Cout,
    output logic         overflow
);

    // Number of slices per operation and the counter that walks them
    localparam int NS = N / W;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [IW-1:0] idx_q;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;      // already inverted for subtraction
    logic [N-1:0]  s_q;
    logic          carry_q;  // carry chained from the previous slice
    logic          cout_q;
    logic          ovf_q;

    logic [W-1:0]  a_slice;
    logic [W-1:0]  b_slice;
    logic [W:0]    slice_sum;
    logic          carry_into_msb;

    // Add the active slice with the chained carry; the MSB carry-in is recovered from the sum bit
    always_comb begin
        a_slice        = a_q[W*idx_q +: W];
        b_slice        = b_q[W*idx_q +: W];
        slice_sum      = {1'b0, a_slice} + {1'b0, b_slice} + {{W{1'b0}}, carry_q};
        carry_into_msb = a_slice[W-1] ^ b_slice[W-1] ^ slice_sum[W-1];
    end

    // Control FSM and datapath registers: accept, walk the slices, hold the result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : Cin;
                        idx_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    s_q[W*idx_q +: W] <= slice_sum[W-1:0];
                    carry_q           <= slice_sum[W];
                    if (idx_q == LAST_IDX) begin
                        cout_q  <= slice_sum[W];
                        ovf_q   <= carry_into_msb ^ slice_sum[W];
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign S         = s_q;
    assign Cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_adder_multicycle.sv
// tb/tb_adder_multicycle.sv - Scoreboard bench for adder_multicycle (32/8, 16/16, 32/4 instances)
module tb_adder_multicycle;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  in_valid_v;
    logic [2:0]  in_ready_v;
    logic [2:0]  out_valid_v;
    logic [2:0]  out_ready_v;
    logic [2:0]  cin_v;
    logic [2:0]  sub_v;
    logic [2:0]  cout_v;
    logic [2:0]  ovf_v;
    logic [31:0] a_s [3];
    logic [31:0] b_s [3];
    logic [31:0] s0;
    logic [15:0] s1;
    logic [31:0] s2;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] s;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t sb[$];

    adder_multicycle #(.N(32), .W(8)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_s[0]), .b(b_s[0]), .Cin(cin_v[0]), .sub(sub_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .S(s0), .Cout(cout_v[0]), .overflow(ovf_v[0])
    );

    adder_multicycle #(.N(16), .W(16)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_s[1][15:0]), .b(b_s[1][15:0]), .Cin(cin_v[1]), .sub(sub_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .S(s1), .Cout(cout_v[1]), .overflow(ovf_v[1])
    );

    adder_multicycle #(.N(32), .W(4)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a_s[2]), .b(b_s[2]), .Cin(cin_v[2]), .sub(sub_v[2]),
        .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
        .S(s2), .Cout(cout_v[2]), .overflow(ovf_v[2])
    );

    function automatic logic [31:0] s_of(input int k);
        case (k)
            0:       return s0;
            1:       return {16'h0000, s1};
            default: return s2;
        endcase
    endfunction

    function automatic int ns_of(input int k);
        case (k)
            0:       return 4;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    // Reference: full-width two's complement add, signed overflow from operand/result signs
    function automatic exp_t model(input int k, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        exp_t        r;
        int          n;
        logic [31:0] m;
        logic [31:0] aa;
        logic [31:0] bb;
        logic [32:0] sum;
        n   = (k == 1) ? 16 : 32;
        m   = (k == 1) ? 32'h0000FFFF : 32'hFFFFFFFF;
        aa  = a & m;
        bb  = (sub ? ~b : b) & m;
        sum = {1'b0, aa} + {1'b0, bb} + {32'h0, (sub ? 1'b1 : cin)};
        r.s    = sum[31:0] & m;
        r.cout = sum[n];
        r.ovf  = (aa[n-1] == bb[n-1]) && (r.s[n-1] != aa[n-1]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction on instance k, scrambling the operand inputs while busy
    task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub, input int stall);
        int          n;
        exp_t        e;
        logic [31:0] hs;
        n = 0;
        while (!in_ready_v[k] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_wait", 64'(in_ready_v[k]), 64'd1);
        a_s[k] = a; b_s[k] = b; cin_v[k] = cin; sub_v[k] = sub;
        in_valid_v[k] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[k] = 1'b0;
        sb.push_back(model(k, a, b, cin, sub));
        n = 0;
        while (!out_valid_v[k] && n < 50) begin
            a_s[k]   = $urandom;
            b_s[k]   = $urandom;
            cin_v[k] = 1'($urandom);
            sub_v[k] = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 64'(n), 64'(ns_of(k)));
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 64'd0, 64'd1);
            e.s = '0; e.cout = 1'b0; e.ovf = 1'b0;
        end else begin
            e = sb.pop_front();
        end
        chk("S", 64'(s_of(k)), 64'(e.s));
        chk("Cout", 64'(cout_v[k]), 64'(e.cout));
        chk("overflow", 64'(ovf_v[k]), 64'(e.ovf));
        hs = s_of(k);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("hold_out_valid", 64'(out_valid_v[k]), 64'd1);
            chk("hold_in_ready", 64'(in_ready_v[k]), 64'd0);
            chk("hold_S", 64'(s_of(k)), 64'(hs));
            chk("hold_Cout", 64'(cout_v[k]), 64'(e.cout));
            chk("hold_overflow", 64'(ovf_v[k]), 64'(e.ovf));
        end
        out_ready_v[k] = 1'b1;
        @(posedge clk); #1;
        out_ready_v[k] = 1'b0;
        chk("post_hs_out_valid", 64'(out_valid_v[k]), 64'd0);
        chk("post_hs_in_ready", 64'(in_ready_v[k]), 64'd1);
    endtask

    initial begin
        rst         = 1'b1;
        in_valid_v  = '0;
        out_ready_v = '0;
        cin_v       = '0;
        sub_v       = '0;
        for (int i = 0; i < 3; i++) begin
            a_s[i] = '0;
            b_s[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready_v[0]), 64'd1);
        chk("rst_out_valid", 64'(out_valid_v[0]), 64'd0);
        chk("rst_S", 64'(s0), 64'd0);
        chk("rst_Cout", 64'(cout_v[0]), 64'd0);
        chk("rst_overflow", 64'(ovf_v[0]), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed add/sub vectors, then long backpressure
        run_op(0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 0);
        run_op(0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1);
        run_op(0, 32'h12345678, 32'h0FEDCBA8, 1'b0, 1'b0, 0);
        run_op(0, 32'h00000005, 32'h00000007, 1'b1, 1'b1, 0);
        run_op(0, 32'h80000000, 32'h00000001, 1'b1, 1'b1, 2);
        run_op(0, 32'hDEADBEEF, 32'h01234567, 1'b1, 1'b0, 10);

        // Reset while BUSY at idx=2 discards the operation
        in_valid_v[0] = 1'b1;
        a_s[0] = 32'hFFFFFFFF; b_s[0] = 32'hFFFFFFFF; cin_v[0] = 1'b1; sub_v[0] = 1'b0;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_in_ready", 64'(in_ready_v[0]), 64'd1);
        chk("midrst_out_valid", 64'(out_valid_v[0]), 64'd0);
        chk("midrst_S", 64'(s0), 64'd0);
        chk("midrst_Cout", 64'(cout_v[0]), 64'd0);
        chk("midrst_overflow", 64'(ovf_v[0]), 64'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_pulse", 64'(out_valid_v[0]), 64'd0);
        end
        run_op(0, 32'd3, 32'd4, 1'b0, 1'b0, 0);

        // Single-slice instance
        run_op(1, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 0);
        run_op(1, 32'h00008000, 32'h00000001, 1'b0, 1'b1, 1);

        // Random regression on the W=8 and W=4 instances
        for (int i = 0; i < 30; i++) begin
            run_op(0, $urandom, $urandom, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
            run_op(2, $urandom, $urandom, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end
        run_op(2, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 0);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
